// File: rtl/ladybird_config.sv
// ============================================================================
// Module : ladybird_config (package)
// Brief  : Shared ladybird constants, LSU arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ladybird_config;

  localparam int XLEN                    = 32;
  localparam int LSU_ARB_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_DRAIN = 2'd2
  } lsu_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ladybird_lsu_arbiter_if.sv
// ============================================================================
// Module : ladybird_lsu_arbiter_if
// Brief  : Requester-side and LSU-side buses of the shared LSU port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ladybird_lsu_arbiter_if
  import ladybird_config::*;
#(
  parameter int N_REQ = 2
) ();

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0][XLEN-1:0] req_addr;
  logic [N_REQ-1:0][XLEN-1:0] req_data;
  logic [N_REQ-1:0]           req_we;
  logic [N_REQ-1:0][2:0]      req_funct;
  logic [N_REQ-1:0]           req_fence;
  logic [N_REQ-1:0]           rsp_valid;
  logic [XLEN-1:0]            rsp_data;
  logic [N_REQ-1:0]           rsp_error;

  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [XLEN-1:0]            lsu_addr;
  logic [XLEN-1:0]            lsu_data;
  logic                       lsu_we;
  logic [2:0]                 lsu_funct;
  logic                       lsu_fence;
  logic                       lsu_rsp_valid;
  logic [XLEN-1:0]            lsu_rsp_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_data, req_we, req_funct, req_fence,
    input  lsu_ready, lsu_rsp_valid, lsu_rsp_data,
    output req_ready, rsp_valid, rsp_data, rsp_error,
    output lsu_valid, lsu_addr, lsu_data, lsu_we, lsu_funct, lsu_fence
  );

  // Requesters plus LSU environment side
  modport master (
    output req_valid, req_addr, req_data, req_we, req_funct, req_fence,
    output lsu_ready, lsu_rsp_valid, lsu_rsp_data,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
    input  lsu_valid, lsu_addr, lsu_data, lsu_we, lsu_funct, lsu_fence
  );

endinterface

`default_nettype wire

// File: rtl/ladybird_rr_arbiter.sv
// ============================================================================
// Module : ladybird_rr_arbiter
// Brief  : Combinational N-way round-robin pick; scans ptr+1 .. ptr (mod N).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ladybird_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[IW'(j)]) begin
        any             = 1'b1;
        grant[IW'(j)]   = 1'b1;
        idx             = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ladybird_lsu_arbiter.sv
// ============================================================================
// Module : ladybird_lsu_arbiter
// Brief  : Round-robin share of the single-outstanding LSU data port.
//          Optional WAIT timeout: LADYBIRD_LSU_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ladybird_lsu_arbiter
  import ladybird_config::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = LSU_ARB_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  ladybird_lsu_arbiter_if.slave  bus,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);

  lsu_arb_state_t   state, state_nxt;
  logic [IW-1:0]    rr_ptr, lock_id, owner, winner, arb_idx;
  logic             lock_vld, arb_any, req_any;
  logic [N_REQ-1:0] arb_grant, win_onehot;

  ladybird_rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A stalled grant stays with its requester even if others raise valid.
  assign winner     = lock_vld ? lock_id : arb_idx;
  assign win_onehot = lock_vld ? (N_REQ'(1) << lock_id) : arb_grant;
  assign req_any    = arb_any | lock_vld;
  assign busy       = (state != ARB_IDLE);

`ifdef LADYBIRD_LSU_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ARB_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_nxt     = state;
    bus.lsu_valid = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_data  = '0;
    bus.lsu_we    = 1'b0;
    bus.lsu_funct = '0;
    bus.lsu_fence = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_error = '0;
    case (state)
      ARB_IDLE: begin
        if (req_any) begin
          bus.lsu_valid = 1'b1;
          bus.lsu_addr  = bus.req_addr[winner];
          bus.lsu_data  = bus.req_data[winner];
          bus.lsu_we    = bus.req_we[winner];
          bus.lsu_funct = bus.req_funct[winner];
          bus.lsu_fence = bus.req_fence[winner];
          bus.req_ready = win_onehot & {N_REQ{bus.lsu_ready}};
          if (bus.lsu_ready) state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.lsu_rsp_valid) begin
          bus.rsp_valid[owner] = 1'b1;
          bus.rsp_data         = bus.lsu_rsp_data;
          state_nxt            = ARB_IDLE;
        end
`ifdef LADYBIRD_LSU_ARB_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          bus.rsp_valid[owner] = 1'b1;
          bus.rsp_error[owner] = 1'b1;
          state_nxt            = ARB_DRAIN;
        end
`endif
      end
`ifdef LADYBIRD_LSU_ARB_TIMEOUT_EN
      // The abandoned LSU response still arrives; swallow it here.
      ARB_DRAIN: begin
        if (bus.lsu_rsp_valid) state_nxt = ARB_IDLE;
      end
`endif
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= IW'(N_REQ - 1);
      lock_vld <= 1'b0;
      lock_id  <= '0;
      owner    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && req_any) begin
        if (bus.lsu_ready) begin
          owner    <= winner;
          rr_ptr   <= winner;
          lock_vld <= 1'b0;
        end else begin
          lock_vld <= 1'b1;
          lock_id  <= winner;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ladybird_lsu_arbiter.sv
// ============================================================================
// Module : tb_ladybird_lsu_arbiter
// Brief  : Directed vector table, corner sequences and random scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ladybird_lsu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ladybird_lsu_arbiter_if #(.N_REQ(2)) bus ();

  ladybird_lsu_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  typedef struct {
    logic [1:0]  rv;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        ev;
    logic [1:0]  erdy;
    logic [31:0] eaddr;
    logic [1:0]  ersp;
    logic [31:0] edata;
    logic        ebusy;
  } vec_t;

  vec_t vt [14];

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic rdy, input logic rspv, input logic [31:0] rspd);
    bus.req_valid     = rv;
    bus.lsu_ready     = rdy;
    bus.lsu_rsp_valid = rspv;
    bus.lsu_rsp_data  = rspd;
  endtask

  initial begin
    int         accepted, responded, cyc, dly, own;
    logic [1:0] pend;
    logic       outst, rspv_now;

    bus.req_addr  = '{A1, A0};
    bus.req_data  = '{D1, D0};
    bus.req_we    = 2'b01;
    bus.req_funct = '{3'b100, 3'b010};
    bus.req_fence = 2'b00;
    drive(2'b00, 1'b0, 1'b0, 32'h0);

    // rv rdy rspv rspd | lsu_valid req_ready lsu_addr rsp_valid rsp_data busy
    vt[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 32'h0, 2'b00, 32'h0,        1'b0};
    vt[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, A0,    2'b00, 32'h0,        1'b0};
    vt[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00, 32'h0, 2'b00, 32'h0,        1'b1};
    vt[3]  = '{2'b11, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 2'b00, 32'h0, 2'b01, 32'h1111_1111, 1'b1};
    vt[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, A1,    2'b00, 32'h0,        1'b0};
    vt[5]  = '{2'b11, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 2'b00, 32'h0, 2'b10, 32'h2222_2222, 1'b1};
    vt[6]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, A0,    2'b00, 32'h0,        1'b0};
    vt[7]  = '{2'b11, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 2'b00, 32'h0, 2'b01, 32'h3333_3333, 1'b1};
    vt[8]  = '{2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, A1,    2'b00, 32'h0,        1'b0};
    vt[9]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, A1,    2'b00, 32'h0,        1'b0};
    vt[10] = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, A1,    2'b00, 32'h0,        1'b0};
    vt[11] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, A1,    2'b00, 32'h0,        1'b0};
    vt[12] = '{2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1};
    vt[13] = '{2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 2'b00, 32'h0, 2'b00, 32'h0,        1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_lsu_valid", 32'(bus.lsu_valid), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive(vt[v].rv, vt[v].rdy, vt[v].rspv, vt[v].rspd);
      #1;
      check($sformatf("v%0d_lsu_valid", v), 32'(bus.lsu_valid), 32'(vt[v].ev));
      check($sformatf("v%0d_req_ready", v), 32'(bus.req_ready), 32'(vt[v].erdy));
      check($sformatf("v%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'(vt[v].ersp));
      check($sformatf("v%0d_rsp_data", v), bus.rsp_data, vt[v].edata);
      check($sformatf("v%0d_rsp_error", v), 32'(bus.rsp_error), 32'd0);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vt[v].ebusy));
      if (vt[v].ev) begin
        check($sformatf("v%0d_lsu_addr", v), bus.lsu_addr, vt[v].eaddr);
        check($sformatf("v%0d_lsu_data", v), bus.lsu_data, (vt[v].eaddr == A0) ? D0 : D1);
        check($sformatf("v%0d_lsu_we", v), 32'(bus.lsu_we), (vt[v].eaddr == A0) ? 32'd1 : 32'd0);
      end
    end

    // Load to requester 1, response five cycles after acceptance
    @(negedge clk);
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    #1;
    check("ld_grant", 32'(bus.req_ready), 32'b10);
    check("ld_funct", 32'(bus.lsu_funct), 32'b100);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(2'b00, 1'b1, (k == 5), (k == 5) ? 32'hDEAD_BEEF : 32'h0);
      #1;
      check($sformatf("ld_wait%0d_busy", k), 32'(busy), 32'd1);
      check($sformatf("ld_wait%0d_rsp", k), 32'(bus.rsp_valid), (k == 5) ? 32'b10 : 32'b00);
    end
    check("ld_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    check("ld_busy_after", 32'(busy), 32'd0);

    // Reset pulsed in WAIT; late response must vanish; pointer back to reset
    @(negedge clk);
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    #1;
    check("rstw_grant", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    check("rstw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0000);
    #1;
    check("rstw_late_rsp", 32'(bus.rsp_valid), 32'b00);
    check("rstw_late_data", bus.rsp_data, 32'h0);
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    #1;
    check("rstw_next_grant", 32'(bus.req_ready), 32'b01);

`ifdef LADYBIRD_LSU_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(2'b00, 1'b1, 1'b0, 32'h0);
      #1;
      check($sformatf("to_c%0d_err", k), 32'(bus.rsp_error), (k == 8) ? 32'b01 : 32'b00);
      check($sformatf("to_c%0d_rsp", k), 32'(bus.rsp_valid), (k == 8) ? 32'b01 : 32'b00);
    end
    check("to_rsp_data", bus.rsp_data, 32'h0);
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    #1;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_ready", 32'(bus.req_ready), 32'b00);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b1, 32'hFACE_FACE);
    #1;
    check("drain_drop", 32'(bus.rsp_valid), 32'b00);
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    #1;
    check("to_next_grant", 32'(bus.req_ready), 32'b10);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b1, 32'h7777_7777);
    #1;
    check("to_next_rsp", 32'(bus.rsp_valid), 32'b10);
`else
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b1, 32'h1234_5678);
    #1;
    check("nto_rsp", 32'(bus.rsp_valid), 32'b01);
    check("nto_err", 32'(bus.rsp_error), 32'b00);
`endif

    // Random traffic: every acceptance gets exactly one response, to its owner
    accepted  = 0;
    responded = 0;
    cyc       = 0;
    dly       = 0;
    own       = 0;
    pend      = 2'b00;
    outst     = 1'b0;
    while (accepted < 600 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]         = 1'b1;
          bus.req_addr[i] = $urandom;
        end
      end
      rspv_now = outst && (dly == 0);
      drive(pend, 1'($urandom_range(0, 1)), rspv_now, $urandom);
      #1;
      if (rspv_now) begin
        check("rnd_rsp_owner", 32'(bus.rsp_valid), 32'(2'b01 << own));
        check("rnd_rsp_data", bus.rsp_data, bus.lsu_rsp_data);
        outst = 1'b0;
        responded++;
      end else begin
        check("rnd_no_rsp", 32'(bus.rsp_valid), 32'b00);
        if (outst) dly--;
      end
      if (bus.req_ready != 2'b00) begin
        own = bus.req_ready[1] ? 1 : 0;
        check("rnd_accept_legal",
              32'($onehot(bus.req_ready) && ((bus.req_ready & ~pend) == 2'b00)
                  && bus.lsu_ready && !outst && !rspv_now), 32'd1);
        check("rnd_accept_addr", bus.lsu_addr, bus.req_addr[own]);
        pend[own] = 1'b0;
        outst     = 1'b1;
        dly       = $urandom_range(0, 3);
        accepted++;
      end
    end
    check("rnd_completed", 32'(accepted >= 600), 32'd1);
    check("rnd_rsp_count", 32'(responded), 32'(accepted - int'(outst)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
